// File: rtl/uart_port_bridge.sv
// ASCII hex command interpreter: UART byte stream in, port-bus reads/writes out.
// Replies to 'r' with one raw byte or two uppercase hex characters.
module uart_port_bridge #(
  parameter int ADDR_W          = 8,
  parameter int HEX_OUT         = 0,
  parameter int AUTOINC_DEFAULT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_read,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              tx_write,
  output logic [ADDR_W-1:0] port_id,
  output logic [7:0]        out_port,
  output logic              write_strobe,
  output logic              read_strobe,
  input  logic [7:0]        in_port,
  output logic              autoinc,
  output logic [7:0]        err_count,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_RDCAP   = 3'd2,
    S_TXWAIT  = 3'd3,
    S_TXGUARD = 3'd4
  } state_t;

  localparam logic [7:0] CH_M  = 8'h6D;
  localparam logic [7:0] CH_W  = 8'h77;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_I  = 8'h69;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Returns {is_hex, nibble} for an ASCII character.
  function automatic logic [4:0] f_hex_decode(input logic [7:0] c);
    logic [4:0] v;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      v = {1'b1, c[3:0] + 4'd9};
    end else begin
      v = 5'd0;
    end
    return v;
  endfunction

  function automatic logic [7:0] f_hex_char(input logic [3:0] n);
    logic [7:0] ch;
    if (n < 4'd10) begin
      ch = {4'h3, n};
    end else begin
      ch = 8'h37 + {4'h0, n};
    end
    return ch;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_acc;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_cmd, r_rdata, r_out_port, r_tx_data, r_err_count;
  logic              r_idx, r_inc_pend, r_autoinc, r_busy;
  logic              r_rx_read, r_write_strobe, r_read_strobe, r_tx_write;
  logic              w_rx_read, w_write_strobe, w_read_strobe, w_tx_write;
  logic [7:0]        w_tx_char;
  logic [4:0]        w_hex;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (rx_valid) w_state_nxt = S_DECODE; else w_state_nxt = S_IDLE;
      S_DECODE:  if (r_cmd == CH_R) w_state_nxt = S_RDCAP; else w_state_nxt = S_IDLE;
      S_RDCAP:   w_state_nxt = S_TXWAIT;
      S_TXWAIT:  if (tx_ready) w_state_nxt = S_TXGUARD; else w_state_nxt = S_TXWAIT;
      S_TXGUARD: if (HEX_OUT != 0 && !r_idx) w_state_nxt = S_TXWAIT; else w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered strobes and the reply character.
  always_comb begin
    w_rx_read      = 1'b0;
    w_write_strobe = 1'b0;
    w_read_strobe  = 1'b0;
    w_tx_write     = 1'b0;
    w_hex          = f_hex_decode(r_cmd);
    if (HEX_OUT == 0)  w_tx_char = r_rdata;
    else if (r_idx)    w_tx_char = f_hex_char(r_rdata[3:0]);
    else               w_tx_char = f_hex_char(r_rdata[7:4]);
    case (r_state)
      S_IDLE:   w_rx_read = rx_valid;
      S_DECODE: begin
        w_write_strobe = (r_cmd == CH_W);
        w_read_strobe  = (r_cmd == CH_R);
      end
      S_TXWAIT: w_tx_write = tx_ready;
      default:  w_rx_read = 1'b0;
    endcase
  end

  // Datapath and registered outputs; a 'w' increment is deferred one cycle so it lands after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc          <= 16'd0;
      r_addr         <= '0;
      r_cmd          <= 8'd0;
      r_rdata        <= 8'd0;
      r_out_port     <= 8'd0;
      r_tx_data      <= 8'd0;
      r_err_count    <= 8'd0;
      r_idx          <= 1'b0;
      r_inc_pend     <= 1'b0;
      r_autoinc      <= (AUTOINC_DEFAULT != 0);
      r_busy         <= 1'b0;
      r_rx_read      <= 1'b0;
      r_write_strobe <= 1'b0;
      r_read_strobe  <= 1'b0;
      r_tx_write     <= 1'b0;
    end else begin
      r_rx_read      <= w_rx_read;
      r_write_strobe <= w_write_strobe;
      r_read_strobe  <= w_read_strobe;
      r_tx_write     <= w_tx_write;
      r_busy         <= (w_state_nxt != S_IDLE);
      if (r_inc_pend) begin
        r_addr     <= r_addr + ADDR_ONE;
        r_inc_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (rx_valid) r_cmd <= rx_data;
        S_DECODE: begin
          if (w_hex[4]) begin
            r_acc <= {r_acc[11:0], w_hex[3:0]};
          end else begin
            case (r_cmd)
              CH_M: begin
                r_addr <= r_acc[ADDR_W-1:0];
                r_acc  <= 16'd0;
              end
              CH_W: begin
                r_out_port <= r_acc[7:0];
                r_acc      <= 16'd0;
                r_inc_pend <= r_autoinc;
              end
              CH_R:  r_acc <= r_acc;
              CH_I:  r_autoinc <= ~r_autoinc;
              CH_SP, CH_CR, CH_LF: r_acc <= r_acc;
              default: begin
                r_acc <= 16'd0;
                if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
              end
            endcase
          end
        end
        S_RDCAP: begin
          r_rdata <= in_port;
          r_idx   <= 1'b0;
          if (r_autoinc) r_addr <= r_addr + ADDR_ONE;
        end
        S_TXWAIT:  if (tx_ready) r_tx_data <= w_tx_char;
        S_TXGUARD: if (HEX_OUT != 0 && !r_idx) r_idx <= 1'b1;
        default:   r_idx <= r_idx;
      endcase
    end
  end

  assign rx_read      = r_rx_read;
  assign tx_data      = r_tx_data;
  assign tx_write     = r_tx_write;
  assign port_id      = r_addr;
  assign out_port     = r_out_port;
  assign write_strobe = r_write_strobe;
  assign read_strobe  = r_read_strobe;
  assign autoinc      = r_autoinc;
  assign err_count    = r_err_count;
  assign busy         = r_busy;

endmodule

// File: doc/uart_port_bridge.md
# uart_port_bridge

Parametrised ASCII command interpreter that turns a byte stream from the board UART into port-bus reads and writes. It sits between the existing `uart_rx`/`uart_tx` byte interfaces and the same `port_id`/`out_port`/`in_port` strobe bus the housekeeping processor drives. This lets the host poke front-end and Ethernet registers with no processor firmware. It extends the original single-byte `xxm`/`xxw`/`r` scheme with:
- wider addresses;
- true hex decoding;
- address auto-increment;
- optional ASCII hex readback;
- error counting.

## Interface

**Parameters**
- `ADDR_W`, default 8: width of `port_id`. Legal range is 4..16.
- `HEX_OUT`, default 0: read reply format. 0 = one raw byte; 1 = two uppercase ASCII hex characters, high nibble first.
- `AUTOINC_DEFAULT`, default 0: reset value of the auto-increment flag.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset; clock `clk`.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: byte available. Level signal, held until consumed.
- `rx_read` out 1: one-cycle consume pulse.
- `tx_data` out 8: byte to transmit. Stable while `tx_write` is high.
- `tx_ready` in 1: transmitter idle.
- `tx_write` out 1: one-cycle transmit pulse.
- `port_id` out `ADDR_W`: current address register.
- `out_port` out 8: write data.
- `write_strobe` out 1: one-cycle write pulse.
- `read_strobe` out 1: one-cycle read pulse.
- `in_port` in 8: read data. Combinational function of `port_id`.
- `autoinc` out 1: auto-increment flag.
- `err_count` out 8: saturating count of illegal characters.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

**Internal registers**
- `acc[15:0]`: hex accumulator.
- `addr[ADDR_W-1:0]`: drives `port_id`.
- `cmd[7:0]`: captured byte.
- `rdata[7:0]`: captured read data.

**Command set** (each byte is decoded once it has been captured):
- `0`-`9`, `a`-`f`, `A`-`F`: `acc <= {acc[11:0], nibble}`. Bits shifted out of the top are discarded.
- `m`: `addr <= acc[ADDR_W-1:0]`, then `acc <= 0`.
- `w`:
  - Issue a write: `out_port = acc[7:0]`, `port_id = addr`.
  - Then `acc <= 0`.
  - If `autoinc` is set, increment `addr` by 1 modulo 2^`ADDR_W`. For example, `ADDR_W=8` wraps FF to 00.
- `r`:
  - Issue a read at `addr`.
  - Transmit the reply.
  - Apply auto-increment as for `w`.
  - `acc` is unchanged.
- `i`: toggle `autoinc`. `acc` is unchanged.
- Space, CR (0x0D), LF (0x0A): ignored. `acc` is unchanged.
- Any other byte: `acc <= 0`, and `err_count` increments, saturating at FF.

**State machine**
- States: IDLE, DECODE, RDCAP, TXWAIT, TXGUARD.
- IDLE:
  - If `rx_valid=1`: `cmd <= rx_data`, `rx_read <= 1`, go to DECODE.
- DECODE:
  - Apply the command.
  - `w` asserts `write_strobe <= 1`.
  - `r` asserts `read_strobe <= 1` and goes to RDCAP.
  - All other commands return to IDLE.
- RDCAP:
  - `rdata <= in_port`, sampled in the same cycle `read_strobe` is high.
  - Apply auto-increment.
  - Set the character index to 0 and go to TXWAIT.
- TXWAIT:
  - When `tx_ready=1`: `tx_write <= 1`, load `tx_data` with the current character, go to TXGUARD.
  - Current character: raw `rdata` if `HEX_OUT=0`; otherwise the hex character of the selected nibble (0-9 maps to 0x30-0x39, A-F maps to 0x41-0x46).
- TXGUARD: a single dead cycle that absorbs `tx_ready` deassertion latency.
  - If `HEX_OUT=1` and the index is 0: index becomes 1, go to TXWAIT.
  - Otherwise go to IDLE.
- No received byte is consumed outside IDLE; bytes stay pending in the UART.

**Reset values**
- All outputs and registers are 0 on reset, with one exception: `autoinc = AUTOINC_DEFAULT`.
- The state returns to IDLE.
- Reset asserted mid-command aborts it, including a pending transmit. No strobe or `tx_write` is issued after reset deasserts.

## Timing

- All outputs are registered. `rx_read`, `write_strobe`, `read_strobe` and `tx_write` are exactly one cycle wide.
- Let N be the cycle in which IDLE samples `rx_valid=1`.
  - `rx_read` is high in N+1.
  - `write_strobe` or `read_strobe` is high in N+2.
  - `port_id`/`out_port` are valid in N+2 and hold until the next `m`, `w` or `r`.
- The address incremented by auto-increment becomes visible on `port_id` in N+3, i.e. after the strobe.
- For non-reply commands the FSM is back in IDLE at N+2, and can sample the next byte there.
- The byte source must drop `rx_valid` by the cycle after `rx_read`.
- Reply timing, assuming `tx_ready` is already high:
  - First `tx_write` in N+4.
  - The second hex character follows no earlier than 2 cycles later, gated by `tx_ready`.
- Throughput is therefore limited only by UART line rate.

## Test plan

- **Hex write.** Send "1a" "m" "5" "5" "w". Expect:
  - `port_id=0x1A`;
  - `out_port=0x55`;
  - one `write_strobe` two cycles after the `w` `rx_valid` is sampled;
  - `acc` then 0.
- **Raw read** (`HEX_OUT=0`). Set `in_port=0xC3` at address 0x07, send "07m" "r". Expect:
  - one `read_strobe`;
  - one `tx_write` with `tx_data=0xC3`;
  - no further tx.
- **Hex read** (`HEX_OUT=1`). Same stimulus, with `tx_ready` held low 10 cycles. Expect:
  - `tx_write` waits for `tx_ready`;
  - bytes 0x43 then 0x33;
  - `busy` low afterwards.
- **Auto-increment and wrap** (`ADDR_W=8`). Send "FFm", "i", "01w", "02w". Expect:
  - writes at 0xFF then 0x00;
  - `autoinc=1`;
  - final `port_id=0x01`.
- **Error handling.** Send "3", "z", "w". Expect:
  - `err_count=1`;
  - write of 0x00;
  - 300 illegal bytes saturate `err_count` at 0xFF;
  - space, CR and LF leave `acc` untouched.
- **Reset mid-reply.** Assert `reset` during TXWAIT. Expect:
  - no `tx_write` afterwards;
  - `port_id=0`, `autoinc=AUTOINC_DEFAULT`;
  - the next "r" reads address 0.
